// File: rtl/pc_fetch_unit_if.sv
// Bundle of controller, instruction-memory and datapath signals around pc_fetch_unit.
// slave: the fetch unit's view. master: the controller/memory/bench side.
interface pc_fetch_unit_if #(
  parameter int unsigned AW = 8
);
  // Controller requests
  logic          PC_RST;
  logic          PC_WRITE;
  logic          PC_SEL;
  logic          BR_SEL;
  // Instruction memory
  logic          IMEM_ACK;
  logic [31:0]   IMEM_DATA;
  logic          IMEM_REQ;
  logic [AW-1:0] IMEM_ADDR;
  // Results back to controller / datapath
  logic [31:0]   INSTR;
  logic [3:0]    OPCODE;
  logic [3:0]    MM;
  logic          IR_VALID;
  logic          BUSY;
  logic [AW-1:0] PC_OUT;
  logic          FETCH_ERR;

  modport slave (
    input  PC_RST, PC_WRITE, PC_SEL, BR_SEL, IMEM_ACK, IMEM_DATA,
    output IMEM_REQ, IMEM_ADDR, INSTR, OPCODE, MM, IR_VALID, BUSY, PC_OUT, FETCH_ERR
  );

  modport master (
    output PC_RST, PC_WRITE, PC_SEL, BR_SEL, IMEM_ACK, IMEM_DATA,
    input  IMEM_REQ, IMEM_ADDR, INSTR, OPCODE, MM, IR_VALID, BUSY, PC_OUT, FETCH_ERR
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter + instruction register with a req/ack instruction fetch.
// A rising edge on PC_WRITE starts one fetch from PC, or from a branch target computed
// from the current IR (absolute or PC-relative). On ACK the IR is loaded and PC = addr + 1.
// Optional macro FETCH_TIMEOUT_EN: abort a fetch after TIMEOUT cycles without ACK,
// loading a NOP and setting the sticky FETCH_ERR flag. Without it REQ waits forever.
module pc_fetch_unit #(
  parameter int unsigned AW        = 8,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned TIMEOUT   = 16
) (
  input logic            CLK,
  input logic            RST_F,
  pc_fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  localparam logic [AW-1:0] ResetPc = AW'(RESET_VEC);

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] imem_addr_q;
  logic [31:0]   instr_q;
  logic          ir_valid_q;
  logic          imem_req_q;
  logic          busy_q;
  logic          pc_write_q;

  logic          go;
  logic [AW-1:0] rel_off;
  logic [AW-1:0] target;
  logic [AW-1:0] fetch_addr;
  logic [AW-1:0] pc_next;

`ifdef FETCH_TIMEOUT_EN
  logic       fetch_err_q;
  logic [7:0] wait_cnt_q;
  logic [7:0] wait_cnt_d;
  logic       timeout;

  // Wait counter advance and timeout detect while REQ sees no ACK
  always_comb begin
    wait_cnt_d = wait_cnt_q + 8'd1;
    timeout    = (wait_cnt_d == 8'(TIMEOUT));
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Fetch start detect and branch target / fetch address selection
  always_comb begin
    go         = bus.PC_WRITE & ~pc_write_q;
    // Sign-extend the 16-bit displacement, then wrap to the PC width
    rel_off    = AW'($signed(instr_q[15:0]));
    target     = bus.BR_SEL ? instr_q[AW-1:0] : (pc_q + rel_off);
    fetch_addr = bus.PC_SEL ? target : pc_q;
    // PC follows the fetched word; wraps naturally at 2^AW
    pc_next    = imem_addr_q + AW'(1);
  end

  // Fetch FSM with all outputs registered
  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      state_q     <= StIdle;
      pc_q        <= ResetPc;
      imem_addr_q <= '0;
      instr_q     <= '0;
      ir_valid_q  <= 1'b0;
      imem_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      pc_write_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fetch_err_q <= 1'b0;
      wait_cnt_q  <= '0;
`endif
    end else if (bus.PC_RST) begin
      // Controller reset aborts any fetch; FETCH_ERR survives until RST_F
      state_q     <= StIdle;
      pc_q        <= ResetPc;
      imem_addr_q <= '0;
      instr_q     <= '0;
      ir_valid_q  <= 1'b0;
      imem_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      pc_write_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      pc_write_q <= bus.PC_WRITE;
      unique case (state_q)
        StIdle: begin
          // PC_SEL/BR_SEL matter only here; the address is frozen for the whole REQ
          if (go) begin
            imem_addr_q <= fetch_addr;
            imem_req_q  <= 1'b1;
            busy_q      <= 1'b1;
            ir_valid_q  <= 1'b0;
            state_q     <= StReq;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
          end
        end
        StReq: begin
          if (bus.IMEM_ACK) begin
            instr_q    <= bus.IMEM_DATA;
            ir_valid_q <= 1'b1;
            pc_q       <= pc_next;
            imem_req_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= StDone;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (timeout) begin
            // Give up: hand the controller a NOP and flag the error
            instr_q     <= '0;
            ir_valid_q  <= 1'b1;
            fetch_err_q <= 1'b1;
            pc_q        <= pc_next;
            imem_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StDone;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
`endif
        end
        StDone: begin
          // Turnaround cycle; a PC_WRITE edge seen here is dropped
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.IMEM_REQ  = imem_req_q;
  assign bus.IMEM_ADDR = imem_addr_q;
  assign bus.INSTR     = instr_q;
  assign bus.OPCODE    = instr_q[31:28];
  assign bus.MM        = instr_q[27:24];
  assign bus.IR_VALID  = ir_valid_q;
  assign bus.BUSY      = busy_q;
  assign bus.PC_OUT    = pc_q;
`ifdef FETCH_TIMEOUT_EN
  assign bus.FETCH_ERR = fetch_err_q;
`else
  assign bus.FETCH_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit (AW=8, RESET_VEC=0, TIMEOUT=16).
// The reference model works per fetch transaction: expected address from PC/IR rules,
// then PC and IR updated once the fetch completes.
module tb_pc_fetch_unit;

  logic clk;
  logic rst_f;

  pc_fetch_unit_if #(.AW(8)) bus_if ();

  pc_fetch_unit #(
    .AW       (8),
    .RESET_VEC(0),
    .TIMEOUT  (16)
  ) dut (
    .CLK  (clk),
    .RST_F(rst_f),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  int          m_pc;
  logic [31:0] m_instr;
  bit          m_irv;
  bit          m_err;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int exp_target(input bit sel, input bit bsel);
    int rel;
    if (!sel) return m_pc;
    if (bsel) return int'(m_instr & 32'hFF);
    rel = int'($signed(m_instr[15:0]));
    return (((m_pc + rel) % 256) + 256) % 256;
  endfunction

  task automatic check_idle_state(input string tag);
    check_eq({tag, "_req"}, 32'(bus_if.IMEM_REQ), 32'd0);
    check_eq({tag, "_busy"}, 32'(bus_if.BUSY), 32'd0);
    check_eq({tag, "_instr"}, bus_if.INSTR, m_instr);
    check_eq({tag, "_pc"}, 32'(bus_if.PC_OUT), 32'(m_pc));
    check_eq({tag, "_irv"}, 32'(bus_if.IR_VALID), 32'(m_irv));
    check_eq({tag, "_err"}, 32'(bus_if.FETCH_ERR), 32'(m_err));
  endtask

  // One complete fetch: PC_WRITE held `hold` cycles, ACK after `delay` extra REQ cycles
  task automatic do_fetch(input bit sel, input bit bsel, input int delay,
                          input logic [31:0] data, input int hold);
    int fa;
    int edges;
    fa = exp_target(sel, bsel);
    @(posedge clk); #1;
    bus_if.PC_WRITE = 1'b1;
    bus_if.PC_SEL   = sel;
    bus_if.BR_SEL   = bsel;
    bus_if.IMEM_ACK = 1'b0;
    edges = 0;
    for (int k = 0; k <= delay; k++) begin
      @(posedge clk); #1;
      edges++;
      if (edges >= hold) bus_if.PC_WRITE = 1'b0;
      // Selects may change freely once the fetch is launched
      bus_if.PC_SEL    = 1'($urandom);
      bus_if.BR_SEL    = 1'($urandom);
      bus_if.IMEM_ACK  = (k == delay);
      bus_if.IMEM_DATA = (k == delay) ? data : $urandom;
      #1;
      check_eq("req_hi", 32'(bus_if.IMEM_REQ), 32'd1);
      check_eq("addr", 32'(bus_if.IMEM_ADDR), 32'(fa));
      check_eq("busy_hi", 32'(bus_if.BUSY), 32'd1);
      check_eq("irv_lo", 32'(bus_if.IR_VALID), 32'd0);
    end
    @(posedge clk); #1;
    edges++;
    if (edges >= hold) bus_if.PC_WRITE = 1'b0;
    // ACK outside REQ must be ignored
    bus_if.IMEM_ACK  = 1'($urandom);
    bus_if.IMEM_DATA = $urandom;
    m_pc    = (fa + 1) % 256;
    m_instr = data;
    m_irv   = 1'b1;
    #1;
    check_eq("opcode", 32'(bus_if.OPCODE), 32'(data[31:28]));
    check_eq("mm", 32'(bus_if.MM), 32'(data[27:24]));
    check_idle_state("done");
    while (bus_if.PC_WRITE) begin
      @(posedge clk); #1;
      edges++;
      if (edges >= hold) bus_if.PC_WRITE = 1'b0;
      bus_if.IMEM_ACK  = 1'($urandom);
      bus_if.IMEM_DATA = $urandom;
      #1;
      check_idle_state("held");
    end
    @(posedge clk); #1;
    bus_if.IMEM_ACK  = 1'($urandom);
    bus_if.IMEM_DATA = $urandom;
    #1;
    check_idle_state("idle");
    @(posedge clk); #1;
    bus_if.IMEM_ACK = 1'b0;
  endtask

  // Start a fetch and leave it sitting in REQ (no ACK)
  task automatic launch_only();
    @(posedge clk); #1;
    bus_if.PC_WRITE = 1'b1;
    bus_if.PC_SEL   = 1'b0;
    bus_if.IMEM_ACK = 1'b0;
    @(posedge clk); #1;
    bus_if.PC_WRITE = 1'b0;
    #1;
    check_eq("launch_req", 32'(bus_if.IMEM_REQ), 32'd1);
    check_eq("launch_addr", 32'(bus_if.IMEM_ADDR), 32'(m_pc));
  endtask

  initial begin
    rst_f            = 1'b0;
    bus_if.PC_RST    = 1'b0;
    bus_if.PC_WRITE  = 1'b0;
    bus_if.PC_SEL    = 1'b0;
    bus_if.BR_SEL    = 1'b0;
    bus_if.IMEM_ACK  = 1'b0;
    bus_if.IMEM_DATA = '0;
    m_pc = 0; m_instr = '0; m_irv = 1'b0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_idle_state("rst");
    check_eq("rst_addr", 32'(bus_if.IMEM_ADDR), 32'd0);
    @(negedge clk);
    rst_f = 1'b1;

    // Plain sequential fetch, ACK in first REQ cycle
    do_fetch(1'b0, 1'b0, 0, 32'h8800_0003, 1);
    // Build PC=6, IR=5000_FFFE, then relative branch -2 -> addr 4, PC 5
    do_fetch(1'b0, 1'b0, 0, 32'h1000_0005, 1);
    do_fetch(1'b1, 1'b1, 1, 32'h5000_FFFE, 2);
    do_fetch(1'b1, 1'b0, 0, 32'h4000_00F0, 1);
    // Absolute to 0xF0, then to 0xFF, whose completion wraps PC to 0
    do_fetch(1'b1, 1'b1, 0, 32'h4000_00FF, 1);
    do_fetch(1'b1, 1'b1, 0, 32'h2000_001F, 1);
    do_fetch(1'b0, 1'b0, 0, 32'h0000_0000, 1);
    // Level held 5 cycles with a delayed ACK: one fetch only
    do_fetch(1'b0, 1'b0, 2, 32'h2000_001F, 5);
    // Absolute jump to 0x1F, PC becomes 0x20
    do_fetch(1'b1, 1'b1, 0, 32'h3300_0040, 1);

    // PC_RST while in REQ
    launch_only();
    bus_if.PC_RST = 1'b1;
    @(posedge clk); #1;
    bus_if.PC_RST = 1'b0;
    m_pc = 0; m_instr = '0; m_irv = 1'b0;
    #1;
    check_idle_state("pcrst");
    check_eq("pcrst_addr", 32'(bus_if.IMEM_ADDR), 32'd0);

    // Async reset mid-REQ, observed with no clock edge in between
    do_fetch(1'b0, 1'b0, 0, 32'h7700_0010, 1);
    launch_only();
    #1 rst_f = 1'b0;
    m_pc = 0; m_instr = '0; m_irv = 1'b0; m_err = 1'b0;
    #1;
    check_idle_state("arst");
    check_eq("arst_addr", 32'(bus_if.IMEM_ADDR), 32'd0);
    @(negedge clk);
    rst_f = 1'b1;

`ifdef FETCH_TIMEOUT_EN
    begin
      int fa;
      do_fetch(1'b0, 1'b0, 0, 32'h6600_0041, 1);
      fa = m_pc;
      launch_only();
      for (int k = 1; k < 16; k++) begin
        @(posedge clk); #2;
        check_eq("to_req", 32'(bus_if.IMEM_REQ), 32'd1);
      end
      @(posedge clk); #2;
      m_pc = (fa + 1) % 256; m_instr = '0; m_irv = 1'b1; m_err = 1'b1;
      check_idle_state("timeout");
      check_eq("to_opcode", 32'(bus_if.OPCODE), 32'd0);
      @(posedge clk); #1;
      bus_if.PC_RST = 1'b1;
      @(posedge clk); #1;
      bus_if.PC_RST = 1'b0;
      m_pc = 0; m_irv = 1'b0;
      #1;
      check_idle_state("to_pcrst");
      @(negedge clk);
      rst_f = 1'b0;
      m_err = 1'b0;
      #1;
      check_idle_state("to_arst");
      @(negedge clk);
      rst_f = 1'b1;
    end
`endif

    // Randomized fetches against the model
    for (int i = 0; i < 40; i++) begin
      do_fetch(1'($urandom), 1'($urandom), int'($urandom_range(0, 4)), $urandom,
               int'($urandom_range(1, 5)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
